// File: rtl/sc_config_frame_commit.sv
// Double-buffered scan-converter config bank: Avalon writes fill staging regs, which are copied
// to the active outputs atomically after a frame start. Optional ARMED timeout: SC_CFG_COMMIT_TIMEOUT_EN.
module sc_config_frame_commit #(
   parameter int NUM_REGS       = 11,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [3:0]               avalon_s_address,
   input  logic [31:0]              avalon_s_writedata,
   input  logic [3:0]               avalon_s_byteenable,
   input  logic                     avalon_s_write,
   input  logic                     avalon_s_read,
   input  logic                     avalon_s_chipselect,
   output logic [31:0]              avalon_s_readdata,
   output logic                     avalon_s_waitrequest_n,
   input  logic                     frame_start_i,
   output logic [NUM_REGS*32-1:0]   cfg_active_o,
   output logic                     cfg_update_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_COMMIT} state_t;

   state_t      state_reg, state_next;
   logic [31:0] staging_reg [NUM_REGS];
   logic [31:0] active_reg  [NUM_REGS];
   logic        update_reg;
   logic [7:0]  commit_cnt_reg;
   logic        timeout_flag;
   logic        timeout_hit;
   logic        wr_en, ctrl_wr, arm_req, force_req;

   // Accesses are only accepted outside the COMMIT cycle; the master holds them otherwise.
   assign avalon_s_waitrequest_n = (state_reg != ST_COMMIT);
   assign wr_en     = avalon_s_chipselect && avalon_s_write && avalon_s_waitrequest_n;
   assign ctrl_wr   = wr_en && (avalon_s_address == 4'hf);
   assign arm_req   = ctrl_wr && avalon_s_writedata[0];
   assign force_req = ctrl_wr && avalon_s_writedata[1];

`ifdef SC_CFG_COMMIT_TIMEOUT_EN
   logic [20:0] timeout_cnt_reg;
   logic        timeout_flag_reg;
   logic        clr_req;

   assign clr_req      = ctrl_wr && avalon_s_writedata[16];
   // A coincident frame start wins over the timeout and leaves the flag clear.
   assign timeout_hit  = (state_reg == ST_ARMED) && !frame_start_i &&
                         (timeout_cnt_reg == 21'(TIMEOUT_CYCLES - 1));
   assign timeout_flag = timeout_flag_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timeout_cnt_reg  <= '0;
         timeout_flag_reg <= 1'b0;
      end else begin
         timeout_cnt_reg <= (state_reg == ST_ARMED) ? timeout_cnt_reg + 21'd1 : 21'd0;
         if (timeout_hit)
            timeout_flag_reg <= 1'b1;
         else if (clr_req)
            timeout_flag_reg <= 1'b0;
      end
   end
`else
   assign timeout_hit  = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (force_req)
               state_next = ST_COMMIT;
            else if (arm_req)
               state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (force_req || frame_start_i || timeout_hit)
               state_next = ST_COMMIT;
         end
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         update_reg     <= 1'b0;
         commit_cnt_reg <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            staging_reg[i] <= '0;
            active_reg[i]  <= '0;
         end
      end else begin
         update_reg <= (state_reg == ST_COMMIT);
         if (state_reg == ST_COMMIT)
            commit_cnt_reg <= commit_cnt_reg + 8'd1;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (state_reg == ST_COMMIT)
               active_reg[i] <= staging_reg[i];
            if (wr_en && (avalon_s_address == 4'(i))) begin
               for (int b = 0; b < 4; b++) begin
                  if (avalon_s_byteenable[b])
                     staging_reg[i][8*b +: 8] <= avalon_s_writedata[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      avalon_s_readdata = '0;
      if (avalon_s_chipselect && avalon_s_read) begin
         if (avalon_s_address == 4'hf) begin
            avalon_s_readdata = {15'd0, timeout_flag, commit_cnt_reg, 6'd0,
                                 (state_reg == ST_COMMIT), (state_reg == ST_ARMED)};
         end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (avalon_s_address == 4'(i))
                  avalon_s_readdata = staging_reg[i];
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_active
         assign cfg_active_o[32*gi +: 32] = active_reg[gi];
      end
   endgenerate

   assign cfg_update_o = update_reg;

endmodule
